// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// Captures two WIDTH-bit operands and a carry-in, then walks an external
// single-bit full adder cell LSB-first, one bit per clock. The cell's sum bit
// is shifted into a result register, and its carry-out is fed back through a
// carry flop. One adder cell is traded for WIDTH cycles of latency.
//
// Handshake: start is sampled only while idle and needs no ready signal.
// busy is high from the cycle after an accepted start up to and including the
// done cycle. done is a single-cycle pulse. sum/cout are valid during done and
// are then held until the next done.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_e1,
    output logic             fa_e2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Next value of the result shifter; also the final sum on the last bit.
    logic [WIDTH-1:0] sum_next;
    assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};

    // Control FSM together with the operand, carry and result datapath.
    // The counter holds at LAST on the exit edge, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_sh <= sum_next;
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt == LAST) begin
                        sum   <= sum_next;
                        cout  <= fa_cout;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status decoded from the registered state.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Cell drives are live only while running; otherwise they are held at zero.
    assign fa_e1  = (state == S_RUN) & a_sh[0];
    assign fa_e2  = (state == S_RUN) & b_sh[0];
    assign fa_cin = (state == S_RUN) & carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl. Two instances (WIDTH=8 and WIDTH=2) are each
// wired to a behavioural full adder cell. Expected results come from plain
// integer addition of the operands.
module tb_serial_adder_ctrl;

    localparam int W  = 8;
    localparam int W2 = 2;

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Counts rising edges; read at falling edges to measure spacing.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // WIDTH=8 instance and its cell.
    logic         start, cin, busy, done, cout;
    logic [W-1:0] a, b, sum;
    logic         fa_e1, fa_e2, fa_cin, fa_sum, fa_cout;
    assign fa_sum  = fa_e1 ^ fa_e2 ^ fa_cin;
    assign fa_cout = (fa_e1 & fa_e2) | (fa_cin & (fa_e1 ^ fa_e2));

    serial_adder_ctrl #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_e1(fa_e1), .fa_e2(fa_e2), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    // WIDTH=2 instance and its cell.
    logic          w2_start, w2_cin, w2_busy, w2_done, w2_cout;
    logic [W2-1:0] w2_a, w2_b, w2_sum;
    logic          w2_e1, w2_e2, w2_fcin, w2_fsum, w2_fcout;
    assign w2_fsum  = w2_e1 ^ w2_e2 ^ w2_fcin;
    assign w2_fcout = (w2_e1 & w2_e2) | (w2_fcin & (w2_e1 ^ w2_e2));

    serial_adder_ctrl #(.WIDTH(W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(w2_start), .a(w2_a), .b(w2_b), .cin(w2_cin),
        .busy(w2_busy), .done(w2_done), .sum(w2_sum), .cout(w2_cout),
        .fa_e1(w2_e1), .fa_e2(w2_e2), .fa_cin(w2_fcin),
        .fa_sum(w2_fsum), .fa_cout(w2_fcout)
    );

    // Counts done pulses on the 8-bit instance.
    int done_cnt8 = 0;
    always @(posedge clk) if (done === 1'b1) done_cnt8 <= done_cnt8 + 1;

    int checks = 0;
    int passed = 0;
    int last_done8 = 0;
    int last_done2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: the full-precision sum of the operands and carry-in.
    function automatic logic [W:0] model8(input logic [W-1:0] x, y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[W:0];
    endfunction

    function automatic logic [W2:0] model2(input logic [W2-1:0] x, y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[W2:0];
    endfunction

    // Drive a start for one cycle from a falling edge, then scramble the inputs.
    task automatic go8(input logic [W-1:0] ta, tb_, input logic tc);
        start = 1'b1; a = ta; b = tb_; cin = tc;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    // Full 8-bit operation from an idle falling edge; returns at the idle edge after done.
    task automatic op8(input string tag, input logic [W-1:0] ta, tb_, input logic tc,
                       input logic [W:0] want, input bit chk_space);
        logic [W:0] prev;
        int edges;
        prev = {cout, sum};
        go8(ta, tb_, tc);
        check({tag, "_busy"}, busy, 1);
        edges = 1;
        while (done !== 1'b1 && edges < 64) begin
            if (edges == W) check({tag, "_hold"}, {cout, sum}, prev);
            @(negedge clk);
            edges++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, edges, W + 1);
        check({tag, "_sum"}, {cout, sum}, want);
        if (chk_space) check({tag, "_space"}, edge_cnt - last_done8, W + 2);
        last_done8 = edge_cnt;
        @(negedge clk);
        check({tag, "_pulse"}, {busy, done}, 2'b00);
    endtask

    // Full 2-bit operation, same shape as op8.
    task automatic op2(input logic [W2-1:0] ta, tb_, input logic tc, input bit chk_space);
        int edges;
        w2_start = 1'b1; w2_a = ta; w2_b = tb_; w2_cin = tc;
        @(negedge clk);
        w2_start = 1'b0; w2_a = W2'($urandom); w2_b = W2'($urandom); w2_cin = 1'($urandom);
        edges = 1;
        while (w2_done !== 1'b1 && edges < 64) begin
            @(negedge clk);
            edges++;
        end
        check("w2_done", w2_done, 1);
        check("w2_lat", edges, W2 + 1);
        check("w2_sum", {w2_cout, w2_sum}, model2(ta, tb_, tc));
        if (chk_space) check("w2_space", edge_cnt - last_done2, W2 + 2);
        last_done2 = edge_cnt;
        @(negedge clk);
        check("w2_pulse", {w2_busy, w2_done}, 2'b00);
    endtask

    initial begin
        int d0;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W2-1:0] qa, qb;
        logic qc;

        // Reset.
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        w2_start = 1'b0; w2_a = '0; w2_b = '0; w2_cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_status", {busy, done}, 2'b00);
        check("rst_result", {cout, sum}, 0);
        check("rst_cell", {fa_e1, fa_e2, fa_cin}, 3'b000);
        check("rst_w2", {w2_busy, w2_done, w2_cout, w2_sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed sums, including the all-ones wrap and the carry-in path.
        op8("s1", 8'h5A, 8'h33, 1'b0, 9'h08D, 1'b0);
        op8("s2a", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        op8("s2b", 8'h00, 8'h00, 1'b1, 9'h001, 1'b1);

        // A start raised mid-run is ignored and not queued.
        d0 = done_cnt8;
        go8(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 6) @(negedge clk);
        check("s3_sum", {cout, sum}, 9'h030);
        check("s3_pulses", done_cnt8 - d0, 1);
        check("s3_idle", busy, 0);

        // Reset in the middle of an operation.
        go8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        d0 = done_cnt8;
        rst_n = 1'b0;
        #1;
        check("s4_busy", busy, 0);
        check("s4_result", {cout, sum}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("s4_nodone", done_cnt8 - d0, 0);
        op8("s4_after", 8'h01, 8'h01, 1'b0, 9'h002, 1'b0);

        // Back-to-back start in the idle cycle right after done.
        op8("s5", 8'h80, 8'h80, 1'b0, 9'h100, 1'b1);

        // Random sweep, 8-bit, every operation back-to-back.
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            op8("rnd8", ra, rb, rc, model8(ra, rb, rc), 1'b1);
        end

        // Random sweep, 2-bit instance.
        for (int i = 0; i < 12; i++) begin
            qa = W2'($urandom);
            qb = W2'($urandom);
            qc = 1'($urandom_range(1, 0));
            op2(qa, qb, qc, i != 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
